// File: rtl/servo_pwm_capture.sv
// Servo PWM receiver: measures high time and period of pwm_in_i, validates each
// frame against timing windows and converts the accepted width to a 0..100 position.
module servo_pwm_capture #(
  parameter int PERIOD_CYCLES = 1_000_000,
  parameter int MIN_PULSE     = 25_000,
  parameter int MAX_PULSE     = 125_000,
  parameter int PERIOD_TOL    = 50_000,
  parameter int PULSE_TOL     = 2_500,
  parameter int CNT_W         = 21
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             pwm_in_i,
  output logic [6:0]       position_o,
  output logic             pos_valid_o,
  output logic [CNT_W-1:0] pulse_width_o,
  output logic             err_pulse_o,
  output logic             err_period_o,
  output logic             signal_lost_o
);

  localparam int DEN   = MAX_PULSE - MIN_PULSE;
  localparam int NUM_W = $clog2(DEN * 100 + 1);
  localparam int WW    = NUM_W + 7;

  localparam logic [CNT_W-1:0] PER_MIN = CNT_W'(PERIOD_CYCLES - PERIOD_TOL);
  localparam logic [CNT_W-1:0] PER_MAX = CNT_W'(PERIOD_CYCLES + PERIOD_TOL);
  localparam logic [CNT_W-1:0] PER_TO  = CNT_W'(PERIOD_CYCLES + PERIOD_TOL + 1);
  localparam logic [CNT_W-1:0] W_MIN   = CNT_W'(MIN_PULSE - PULSE_TOL);
  localparam logic [CNT_W-1:0] W_MAX   = CNT_W'(MAX_PULSE + PULSE_TOL);
  localparam logic [CNT_W-1:0] HI_TO   = CNT_W'(MAX_PULSE + PULSE_TOL + 1);
  localparam logic [CNT_W-1:0] CL_LO   = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] CL_HI   = CNT_W'(MAX_PULSE);

  typedef enum logic [1:0] {WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

  // ---------------- input conditioning ----------------
  logic s1_q, s2_q, s3_q;
  logic rise, fall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= pwm_in_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  // ---------------- measurement FSM ----------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] hi_q, hi_d, per_q, per_d, idle_q, idle_d, width_q, width_d;
  logic             start_div, set_lost, str_pulse, str_period;
  logic             per_ok, width_ok;

  assign per_ok   = (per_q >= PER_MIN) && (per_q <= PER_MAX);
  assign width_ok = (width_q >= W_MIN) && (width_q <= W_MAX);

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    per_d      = per_q;
    idle_d     = idle_q;
    width_d    = width_q;
    start_div  = 1'b0;
    set_lost   = 1'b0;
    str_pulse  = 1'b0;
    str_period = 1'b0;
    if (!en_i) begin
      state_d = WAIT_RISE;
      hi_d    = '0;
      per_d   = '0;
      idle_d  = '0;
      width_d = '0;
    end else begin
      case (state_q)
        WAIT_RISE: begin
          if (rise) begin
            hi_d    = CNT_W'(1);
            per_d   = CNT_W'(1);
            idle_d  = '0;
            state_d = MEAS_HIGH;
          end else if (idle_q == PER_MAX) begin
            set_lost = 1'b1;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
        MEAS_HIGH: begin
          // a fall landing on the timeout cycle still counts as a measured width
          if (fall) begin
            width_d = hi_q;
            per_d   = per_q + 1'b1;
            state_d = MEAS_LOW;
          end else if (hi_q == HI_TO) begin
            str_pulse = 1'b1;
            hi_d      = '0;
            per_d     = '0;
            idle_d    = '0;
            state_d   = WAIT_RISE;
          end else begin
            hi_d  = hi_q + 1'b1;
            per_d = per_q + 1'b1;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            if (!per_ok)        str_period = 1'b1;
            else if (!width_ok) str_pulse  = 1'b1;
            else                start_div  = 1'b1;
            hi_d    = CNT_W'(1);
            per_d   = CNT_W'(1);
            state_d = MEAS_HIGH;
          end else if (per_q == PER_TO) begin
            str_period = 1'b1;
            set_lost   = 1'b1;
            hi_d       = '0;
            per_d      = '0;
            idle_d     = '0;
            state_d    = WAIT_RISE;
          end else begin
            per_d = per_q + 1'b1;
          end
        end
        default: state_d = WAIT_RISE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= WAIT_RISE;
      hi_q    <= '0;
      per_q   <= '0;
      idle_q  <= '0;
      width_q <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      per_q   <= per_d;
      idle_q  <= idle_d;
      width_q <= width_d;
    end
  end

  // ---------------- width to position divider ----------------
  logic             busy_q;
  logic [2:0]       step_q;
  logic [WW-1:0]    rem_q, dsh_q, rem_nx, num_ld;
  logic [5:0]       quo_q;
  logic [6:0]       quo_nx;
  logic [CNT_W-1:0] pw_q, clamped;
  logic             ge, done;

  assign clamped = (width_q < CL_LO) ? CL_LO : ((width_q > CL_HI) ? CL_HI : width_q);
  assign num_ld  = WW'(clamped - CL_LO) * WW'(100);
  assign ge      = rem_q >= dsh_q;
  assign rem_nx  = ge ? (rem_q - dsh_q) : rem_q;
  assign quo_nx  = {quo_q, ge};
  assign done    = en_i && busy_q && (step_q == 3'd6);

  // Quotient never exceeds 100, so seven restoring steps from den<<6 suffice.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      step_q <= '0;
      rem_q  <= '0;
      dsh_q  <= '0;
      quo_q  <= '0;
      pw_q   <= '0;
    end else if (!en_i) begin
      busy_q <= 1'b0;
    end else if (start_div && !busy_q) begin
      busy_q <= 1'b1;
      step_q <= '0;
      rem_q  <= num_ld;
      dsh_q  <= WW'(DEN) << 6;
      quo_q  <= '0;
      pw_q   <= width_q;
    end else if (busy_q) begin
      rem_q  <= rem_nx;
      dsh_q  <= dsh_q >> 1;
      quo_q  <= quo_nx[5:0];
      step_q <= step_q + 3'd1;
      if (step_q == 3'd6) busy_q <= 1'b0;
    end
  end

  // ---------------- output registers ----------------
  logic [6:0]       position_q;
  logic [CNT_W-1:0] pulse_width_q;
  logic             pos_valid_q, err_pulse_q, err_period_q, signal_lost_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      position_q    <= '0;
      pulse_width_q <= '0;
      pos_valid_q   <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_period_q  <= 1'b0;
      signal_lost_q <= 1'b1;
    end else begin
      pos_valid_q  <= done;
      err_pulse_q  <= str_pulse;
      err_period_q <= str_period;
      if (done) begin
        position_q    <= quo_nx;
        pulse_width_q <= pw_q;
        signal_lost_q <= 1'b0;
      end else if (set_lost) begin
        signal_lost_q <= 1'b1;
      end
    end
  end

  assign position_o    = position_q;
  assign pulse_width_o = pulse_width_q;
  assign pos_valid_o   = pos_valid_q;
  assign err_pulse_o   = err_pulse_q;
  assign err_period_o  = err_period_q;
  assign signal_lost_o = signal_lost_q;

endmodule
